mc_core: RTL
============

# mc_core

Parametrised multi-cycle processor core: next generation of our single-cycle top level. It fetches from an instruction memory and accesses data memory through variable-latency request/response handshakes, and sequences each instruction through a small state machine. It exposes a sticky `done` on HALT. Datapath width, register count and PC width are parameters.

## Interface
- `DATA_W`, 8: datapath and register width.
- `NREG`, 16: register count, power of 2, ≥2. Derived `RA_W = $clog2(NREG)`.
- `PC_W`, 8: PC/instruction address width. Derived `INST_W = 4 + 2*RA_W` (12 at defaults).
- `clk` in 1: sole clock.
- `rst` in 1: **synchronous, active-high** reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address, equals PC.
- `imem_rdata` in INST_W: instruction. Sampled only when `imem_rvalid`.
- `imem_rvalid` in 1: fetch response valid.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: 1 for store, 0 for load.
- `dmem_addr` out DATA_W: data address.
- `dmem_wdata` out DATA_W: store data.
- `dmem_rdata` in DATA_W: load data. Sampled only when `dmem_ack`.
- `dmem_ack` in 1: data access complete.
- `done` out 1: high after HALT executes. Sticky until `rst`.

## Operation
- Instruction format: `{op[3:0], rd[RA_W-1:0], rs[RA_W-1:0]}`. R[x] denotes register x. imm is the rs field, sign-extended to DATA_W.
- Opcodes:
  - 0 HALT.
  - 1 ADD: R[rd]+=R[rs].
  - 2 SUB: R[rd]-=R[rs].
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MOVI: R[rd]=imm.
  - 7 LD: R[rd]=mem[R[rs]].
  - 8 ST: mem[R[rs]]=R[rd].
  - 9 BEQZ: if R[rd]==0 then PC=R[rs][PC_W-1:0].
  - 10 JMP: PC=R[rs][PC_W-1:0].
  - 11–15: NOP.
- Arithmetic is modulo 2^DATA_W, with no flags. R0 is an ordinary register.
- PC increments modulo 2^PC_W; 2^PC_W−1 wraps to 0. Branch/jump targets are truncated or zero-extended to PC_W.
- States:
  - FETCH: `imem_req`=1. On `imem_rvalid` latch the instruction and go to EXEC.
  - EXEC: ALU/MOVI/NOP write R[rd] if applicable and update PC → FETCH. BEQZ/JMP update PC → FETCH. LD/ST → MEM. HALT → HALTED.
  - MEM: `dmem_req`=1; `dmem_addr`, `dmem_we` and `dmem_wdata` are held stable. On `dmem_ack`: for LD, write R[rd]=`dmem_rdata`; PC+=1; → FETCH.
  - HALTED: `done`=1, no requests. Remains here until `rst`.
- Register reads in EXEC and MEM use the latched instruction. LD with rd==rs uses the pre-load address.

## Timing
- Reset values:
  - PC=0, state FETCH, all registers 0, `done`=0.
  - `imem_req` becomes 1 in the first cycle after reset deasserts.
  - `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` are 0.
- `imem_rvalid`/`dmem_ack` may arrive in the same cycle the request is first asserted (zero wait) or any later cycle.
- Responses while the matching req=0 are ignored.
- Request outputs are registered or decoded from registered state only, with no combinational input→output path.
- Cycles per instruction, where Wi/Wd are wait cycles before rvalid/ack:
  - ALU, MOVI, NOP, BEQZ, JMP: 2+Wi.
  - LD/ST: 3+Wi+Wd.
  - HALT: `done` rises 2+Wi cycles after FETCH entry.
- Register write and PC update take effect at the clock edge leaving EXEC or MEM. The next FETCH sees the new values.
- `rst` asserted in any state, including mid-MEM with a pending ack, returns to reset values on that edge. A late ack after reset is ignored.
- `rst` held high keeps all requests low.

## Structure
- Package `mc_pkg`:
  - `op_e` opcode enum.
  - `state_e` {FETCH, EXEC, MEM, HALTED}.
  - `INST_W`/`RA_W` helper functions.
- Sub-module `mc_regfile`: NREG×DATA_W, two async read ports, one sync write port, synchronous reset.
- ALU is inline in `mc_core`.

## Test plan
- Zero-wait memories. Program MOVI r1,3; MOVI r2,−1; ADD r1,r2; HALT → r1=2, r2=8'hFF; `done` high in cycle 8 after reset release.
- Variable-latency imem (Wi=3) and dmem (Wd=2). Program MOVI r3,5; ST r3,@r3; LD r4,@r3; HALT → store at addr 5 with data 5; r4=5; `dmem_req` held with stable addr for 3 cycles per access.
- BEQZ loop: r1=0, r2=target 4 → PC jumps to 4. With r1≠0 → PC falls through to next address.
- PC wrap: PC_W=4, NOPs from 0..15 → `imem_addr` sequence 14, 15, 0.
- Reset asserted during MEM before ack; ack pulses next cycle → registers remain 0, state FETCH at PC 0, no write.
- Non-default params DATA_W=16, NREG=4: MOVI r1,−2; SUB r0,r1 → r0=16'h0002.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle core: opcodes, FSM states and width helpers.
package mc_pkg;

    typedef enum logic [3:0] {
        OP_HALT = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_MOVI = 4'd6,
        OP_LD   = 4'd7,
        OP_ST   = 4'd8,
        OP_BEQZ = 4'd9,
        OP_JMP  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_e;

    function automatic int ra_w(input int nreg);
        return $clog2(nreg);
    endfunction

    function automatic int inst_w(input int nreg);
        return 4 + 2 * $clog2(nreg);
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREG x DATA_W, two asynchronous read ports, one synchronous write port.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ra_w(NREG)-1:0]   ra_a,
    input  logic [ra_w(NREG)-1:0]   ra_b,
    output logic [DATA_W-1:0]       rd_a,
    output logic [DATA_W-1:0]       rd_b,
    input  logic                    we,
    input  logic [ra_w(NREG)-1:0]   wa,
    input  logic [DATA_W-1:0]       wd
);

    logic [DATA_W-1:0] regs [NREG];

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle core: FETCH -> EXEC -> (MEM) -> FETCH, with sticky done after HALT.
module mc_core
    import mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 16,
    parameter int PC_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [inst_w(NREG)-1:0]   imem_rdata,
    input  logic                      imem_rvalid,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wdata,
    input  logic [DATA_W-1:0]         dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      done
);

    localparam int RA_W   = ra_w(NREG);
    localparam int INST_W = inst_w(NREG);

    state_e            state;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] ir;

    logic [3:0]        op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              ld_done;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wd;

    assign op        = ir[INST_W-1 -: 4];
    assign rd        = ir[2*RA_W-1 -: RA_W];
    assign rs        = ir[RA_W-1:0];
    assign imm       = DATA_W'(signed'(rs));
    assign pc_inc    = pc + PC_W'(1);
    assign target    = PC_W'(rs_val);
    assign imem_addr = pc;

    mc_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .ra_a (rd),
        .ra_b (rs),
        .rd_a (rd_val),
        .rd_b (rs_val),
        .we   (rf_we),
        .wa   (rd),
        .wd   (rf_wd)
    );

    always_comb begin
        alu_res = rd_val;
        alu_wr  = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = rd_val + rs_val; alu_wr = 1'b1; end
            OP_SUB:  begin alu_res = rd_val - rs_val; alu_wr = 1'b1; end
            OP_AND:  begin alu_res = rd_val & rs_val; alu_wr = 1'b1; end
            OP_OR:   begin alu_res = rd_val | rs_val; alu_wr = 1'b1; end
            OP_XOR:  begin alu_res = rd_val ^ rs_val; alu_wr = 1'b1; end
            OP_MOVI: begin alu_res = imm;             alu_wr = 1'b1; end
            default: begin alu_res = rd_val;          alu_wr = 1'b0; end
        endcase
    end

    // A load retires only on an ack that answers an outstanding request.
    assign ld_done = (state == MEM) && dmem_req && dmem_ack && !dmem_we;
    assign rf_we   = ((state == EXEC) && alu_wr) || ld_done;
    assign rf_wd   = (state == MEM) ? dmem_rdata : alu_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_rvalid) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_HALT: begin
                            done  <= 1'b1;
                            state <= HALTED;
                        end
                        OP_LD, OP_ST: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= rs_val;
                            dmem_wdata <= (op == OP_ST) ? rd_val : '0;
                            state      <= MEM;
                        end
                        OP_BEQZ: begin
                            pc       <= (rd_val == '0) ? target : pc_inc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                        OP_JMP: begin
                            pc       <= target;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                        default: begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
